// File: rtl/exec_pkg.sv
// Shared encodings for the execute stage: mul/div opcodes, forwarding selects,
// iterative-unit states, ALU operations and branch condition codes.
package exec_pkg;

    typedef enum logic [1:0] {
        MD_NONE = 2'b00,
        MD_MUL  = 2'b01,
        MD_DIVU = 2'b10,
        MD_REMU = 2'b11
    } md_op_e;

    localparam logic [1:0] FWD_REG = 2'b00;
    localparam logic [1:0] FWD_MEM = 2'b01;
    localparam logic [1:0] FWD_WB  = 2'b10;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        MUL  = 2'b01,
        DIV  = 2'b10,
        DONE = 2'b11
    } md_state_e;

    localparam logic [3:0] ALU_ADD  = 4'd0;
    localparam logic [3:0] ALU_SUB  = 4'd1;
    localparam logic [3:0] ALU_AND  = 4'd2;
    localparam logic [3:0] ALU_OR   = 4'd3;
    localparam logic [3:0] ALU_XOR  = 4'd4;
    localparam logic [3:0] ALU_SHL  = 4'd5;
    localparam logic [3:0] ALU_SHR  = 4'd6;
    localparam logic [3:0] ALU_SRA  = 4'd7;
    localparam logic [3:0] ALU_PASB = 4'd8;
    localparam logic [3:0] ALU_SLTU = 4'd9;

    // Branch condition field lives in Instr[10:8]; flags come from this ALU result.
    localparam logic [2:0] CC_AL = 3'd0;
    localparam logic [2:0] CC_Z  = 3'd1;
    localparam logic [2:0] CC_NZ = 3'd2;
    localparam logic [2:0] CC_N  = 3'd3;
    localparam logic [2:0] CC_NN = 3'd4;
    localparam logic [2:0] CC_C  = 3'd5;
    localparam logic [2:0] CC_NC = 3'd6;

    function automatic logic cond_met(input logic [2:0] cc, input logic z, input logic n,
                                      input logic c);
        case (cc)
            CC_AL:   cond_met = 1'b1;
            CC_Z:    cond_met = z;
            CC_NZ:   cond_met = !z;
            CC_N:    cond_met = n;
            CC_NN:   cond_met = !n;
            CC_C:    cond_met = c;
            CC_NC:   cond_met = !c;
            default: cond_met = 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/muldiv_iter.sv
// Iterative unsigned multiply / restoring divide, one bit per cycle.
// Holds its result in DONE until the consumer acknowledges it.
module muldiv_iter
    import exec_pkg::*;
#(
    parameter int DATA_W   = 32,
    parameter int MD_CNT_W = 6
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [1:0]        op,
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    input  logic              ack,
    output logic              idle,
    output logic              done,
    output logic [DATA_W-1:0] result
);

    md_state_e             state_reg;
    md_op_e                op_reg;
    logic [MD_CNT_W-1:0]   cnt_reg;
    logic [DATA_W-1:0]     acc_reg;
    logic [DATA_W-1:0]     x_reg;   // multiplicand, or dividend shifting into quotient
    logic [DATA_W-1:0]     y_reg;   // multiplier, or divisor
    logic [DATA_W-1:0]     rem_reg;
    logic [DATA_W:0]       div_shift;
    logic [DATA_W:0]       div_diff;
    logic                  last_iter;

    assign div_shift = {rem_reg, x_reg[DATA_W-1]};
    assign div_diff  = div_shift - {1'b0, y_reg};
    assign last_iter = (cnt_reg == MD_CNT_W'(DATA_W - 1));

    // A zero divisor always passes the trial subtract: quotient all ones, remainder = A.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= IDLE;
            op_reg    <= MD_NONE;
            cnt_reg   <= '0;
            acc_reg   <= '0;
            x_reg     <= '0;
            y_reg     <= '0;
            rem_reg   <= '0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (start) begin
                        op_reg    <= md_op_e'(op);
                        cnt_reg   <= '0;
                        acc_reg   <= '0;
                        rem_reg   <= '0;
                        x_reg     <= a;
                        y_reg     <= b;
                        state_reg <= (md_op_e'(op) == MD_MUL) ? MUL : DIV;
                    end
                end
                MUL: begin
                    if (y_reg[0]) acc_reg <= acc_reg + x_reg;
                    x_reg   <= x_reg << 1;
                    y_reg   <= y_reg >> 1;
                    cnt_reg <= cnt_reg + 1'b1;
                    if (last_iter) state_reg <= DONE;
                end
                DIV: begin
                    if (div_shift >= {1'b0, y_reg}) begin
                        rem_reg <= div_diff[DATA_W-1:0];
                        x_reg   <= {x_reg[DATA_W-2:0], 1'b1};
                    end else begin
                        rem_reg <= div_shift[DATA_W-1:0];
                        x_reg   <= {x_reg[DATA_W-2:0], 1'b0};
                    end
                    cnt_reg <= cnt_reg + 1'b1;
                    if (last_iter) state_reg <= DONE;
                end
                DONE: begin
                    if (ack) state_reg <= IDLE;
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    always_comb begin
        case (op_reg)
            MD_MUL:  result = acc_reg;
            MD_DIVU: result = x_reg;
            default: result = rem_reg;
        endcase
    end

    assign idle = (state_reg == IDLE);
    assign done = (state_reg == DONE);

endmodule

// File: rtl/execute_pipe.sv
// Execute stage: operand forwarding, immediates, single-cycle ALU with branch
// resolution, iterative mul/div, and a valid/ready registered EX/MEM output.
module execute_pipe
    import exec_pkg::*;
#(
    parameter int DATA_W   = 32,
    parameter int PC_W     = 16,
    parameter int MD_CNT_W = 6
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              InValid,
    output logic              InReady,
    input  logic [PC_W-1:0]   PCIn,
    input  logic [DATA_W-1:0] RqRd,
    input  logic [DATA_W-1:0] Rs,
    input  logic [15:0]       Instr,
    input  logic              JumpOrBranchHigh,
    input  logic              RqRdOrImm,
    input  logic              RsOrImm,
    input  logic [3:0]        ALUCtrl,
    input  logic [1:0]        MulDivOp,
    input  logic [1:0]        FwdSelA,
    input  logic [1:0]        FwdSelB,
    input  logic [DATA_W-1:0] FwdMem,
    input  logic [DATA_W-1:0] FwdWb,
    output logic              OutValid,
    input  logic              OutReady,
    output logic [DATA_W-1:0] ALUOut,
    output logic [PC_W-1:0]   PCOut,
    output logic              flush
);

    localparam int SH_W = $clog2(DATA_W);

    logic [DATA_W-1:0] fwd_a, fwd_b, op_a, op_b, alu_res, md_result;
    logic [DATA_W:0]   sum, diff;
    logic              alu_c, alu_z, alu_n, taken;
    logic              accept, alu_load, md_start, md_load, md_idle, md_done;
    logic              out_valid_reg, flush_reg;
    logic [DATA_W-1:0] alu_out_reg;
    logic [PC_W-1:0]   pc_out_reg, md_pc_reg;
    logic              unused_instr;

    assign unused_instr = ^Instr[15:11];

    always_comb begin
        case (FwdSelA)
            FWD_MEM: fwd_a = FwdMem;
            FWD_WB:  fwd_a = FwdWb;
            default: fwd_a = RqRd;
        endcase
        case (FwdSelB)
            FWD_MEM: fwd_b = FwdMem;
            FWD_WB:  fwd_b = FwdWb;
            default: fwd_b = Rs;
        endcase
    end

    assign op_a = RqRdOrImm ? {{(DATA_W-6){1'b0}}, Instr[5:0]} : fwd_a;
    assign op_b = RsOrImm   ? {{(DATA_W-8){1'b0}}, Instr[7:0]} : fwd_b;
    assign sum  = {1'b0, op_a} + {1'b0, op_b};
    assign diff = {1'b0, op_a} - {1'b0, op_b};

    always_comb begin
        alu_res = '0;
        alu_c   = 1'b0;
        case (ALUCtrl)
            ALU_ADD:  begin alu_res = sum[DATA_W-1:0];  alu_c = sum[DATA_W];   end
            ALU_SUB:  begin alu_res = diff[DATA_W-1:0]; alu_c = !diff[DATA_W]; end
            ALU_AND:  alu_res = op_a & op_b;
            ALU_OR:   alu_res = op_a | op_b;
            ALU_XOR:  alu_res = op_a ^ op_b;
            ALU_SHL:  alu_res = op_a << op_b[SH_W-1:0];
            ALU_SHR:  alu_res = op_a >> op_b[SH_W-1:0];
            ALU_SRA:  alu_res = $unsigned($signed(op_a) >>> op_b[SH_W-1:0]);
            ALU_PASB: alu_res = op_b;
            ALU_SLTU: alu_res = {{(DATA_W-1){1'b0}}, (op_a < op_b)};
            default:  alu_res = '0;
        endcase
    end

    assign alu_z = (alu_res == '0);
    assign alu_n = alu_res[DATA_W-1];
    assign taken = JumpOrBranchHigh && cond_met(Instr[10:8], alu_z, alu_n, alu_c);

    assign InReady  = md_idle && (!out_valid_reg || OutReady);
    assign accept   = InValid && InReady;
    assign alu_load = accept && (md_op_e'(MulDivOp) == MD_NONE);
    assign md_start = accept && (md_op_e'(MulDivOp) != MD_NONE);
    assign md_load  = md_done && (!out_valid_reg || OutReady);

    muldiv_iter #(
        .DATA_W   (DATA_W),
        .MD_CNT_W (MD_CNT_W)
    ) u_muldiv (
        .clk    (clk),
        .rst_n  (rst_n),
        .start  (md_start),
        .op     (MulDivOp),
        .a      (op_a),
        .b      (op_b),
        .ack    (md_load),
        .idle   (md_idle),
        .done   (md_done),
        .result (md_result)
    );

    // alu_load and md_load never coincide: an ALU accept needs the mul/div unit idle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_reg <= 1'b0;
            alu_out_reg   <= '0;
            pc_out_reg    <= '0;
            flush_reg     <= 1'b0;
            md_pc_reg     <= '0;
        end else begin
            if (md_start) md_pc_reg <= PCIn;
            if (alu_load) begin
                out_valid_reg <= 1'b1;
                alu_out_reg   <= alu_res;
                pc_out_reg    <= taken ? fwd_a[PC_W-1:0] : PCIn;
                flush_reg     <= taken;
            end else if (md_load) begin
                out_valid_reg <= 1'b1;
                alu_out_reg   <= md_result;
                pc_out_reg    <= md_pc_reg;
                flush_reg     <= 1'b0;
            end else if (OutReady) begin
                out_valid_reg <= 1'b0;
                flush_reg     <= 1'b0;
            end
        end
    end

    assign OutValid = out_valid_reg;
    assign ALUOut   = alu_out_reg;
    assign PCOut    = pc_out_reg;
    assign flush    = flush_reg;

endmodule
